dl166_run_ctrl: RTL and testbench

//  Run-control sequencer for the 4-bit DL166 core. Owns a writable 16x8 program store that replaces
//  the fixed ROM, loads it from a byte stream, and sequences the core via cpu_rst_n/cpu_en:
//  run, bounded run, single-step, halt, PC breakpoint. Sits between the host/UART command path and the core.

---
 rtl/dl166_pkg.sv | 37 +++
 rtl/dl166_prog_ram.sv | 35 +++
 rtl/dl166_run_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dl166_run_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dl166_pkg.sv
// Shared definitions for the DL166 run-control block: command and state
// encodings, the power-on instruction, and small decode helpers.
package dl166_pkg;

  // Instruction every store word holds after reset: JMP 0, a harmless spin.
  localparam logic [7:0] RESET_INSTR = 8'h90;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LOAD    = 3'd1,
    OP_RUN     = 3'd2,
    OP_STEP    = 3'd3,
    OP_HALT    = 3'd4,
    OP_BRK_SET = 3'd5,
    OP_BRK_CLR = 3'd6,
    OP_CLEAR   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  // Commands are only taken while the sequencer is not mid-load or mid-step.
  function automatic logic cmd_ready_in(input state_e st);
    return (st == ST_IDLE) || (st == ST_RUN) || (st == ST_HALT);
  endfunction

  // The core is held out of reset whenever it has (or may have) live state.
  function automatic logic core_live_in(input state_e st);
    return (st == ST_RUN) || (st == ST_STEP) || (st == ST_HALT);
  endfunction

endpackage

// File: rtl/dl166_prog_ram.sv
// Writable program store: register file with async reinitialisation to the
// reset instruction, synchronous write port and combinational read port.
module dl166_prog_ram
  import dl166_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Reset refills every word with the reset instruction; writes land on the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(RESET_INSTR);
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dl166_run_ctrl.sv
// Run-control sequencer for the DL166 core: loads the program store from a
// byte stream and drives cpu_rst_n/cpu_en for run, bounded run, single-step,
// halt and PC breakpoint.
module dl166_run_ctrl
  import dl166_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_arg,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_rst_n,
  output logic              cpu_en,
  output logic [2:0]        state,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  icount
);

  localparam logic [ADDR_W:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [ADDR_W:0]   ld_rem_q, ld_rem_d;
  logic [CNT_W-1:0]  budget_q, budget_d;
  logic              bud_en_q, bud_en_d;
  logic              first_q, first_d;
  logic              bp_en_q, bp_en_d;
  logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
  logic              bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0]  icount_q, icount_d;

  logic bp_fire_s, cpu_en_s, cmd_acc_s, ld_acc_s, we_s;

  dl166_prog_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .waddr (ld_addr_q),
    .wdata (ld_data),
    .raddr (cpu_pc),
    .rdata (cpu_instr)
  );

  // Execute enable: breakpoint blocks execution except on the first cycle after (re)entry.
  always_comb begin
    bp_fire_s = bp_en_q && (cpu_pc == bp_addr_q) && !first_q;
    case (state_q)
      ST_RUN:  cpu_en_s = !bp_fire_s;
      ST_STEP: cpu_en_s = 1'b1;
      default: cpu_en_s = 1'b0;
    endcase
    cmd_acc_s = cmd_valid && cmd_ready_in(state_q);
    ld_acc_s  = ld_valid && (state_q == ST_LOAD);
    we_s      = ld_acc_s;
  end

  // Next-state logic for the sequencer, counters and breakpoint register.
  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    ld_rem_d  = ld_rem_q;
    budget_d  = budget_q;
    bud_en_d  = bud_en_q;
    first_d   = 1'b0;
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    bp_hit_d  = bp_hit_q;
    icount_d  = (cpu_en_s && (icount_q != {CNT_W{1'b1}})) ? icount_q + CNT_W'(1) : icount_q;

    // Breakpoint programming is honoured in every command-accepting state.
    if (cmd_acc_s && (cmd_op == OP_BRK_SET)) begin
      bp_en_d   = 1'b1;
      bp_addr_d = cmd_arg[ADDR_W-1:0];
    end else if (cmd_acc_s && (cmd_op == OP_BRK_CLR)) begin
      bp_en_d = 1'b0;
    end else begin
      bp_en_d = bp_en_q;
    end

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (cmd_acc_s) begin
          case (cmd_op)
            OP_LOAD: begin
              state_d   = ST_LOAD;
              ld_addr_d = {ADDR_W{1'b0}};
              ld_rem_d  = (cmd_arg[ADDR_W-1:0] == {ADDR_W{1'b0}}) ? FULL_DEPTH
                                                                  : {1'b0, cmd_arg[ADDR_W-1:0]};
              bp_hit_d  = 1'b0;
            end
            OP_RUN: begin
              state_d  = ST_RUN;
              budget_d = cmd_arg;
              bud_en_d = (cmd_arg != {CNT_W{1'b0}});
              first_d  = 1'b1;
              bp_hit_d = 1'b0;
            end
            OP_STEP: begin
              state_d  = ST_STEP;
              first_d  = 1'b1;
              bp_hit_d = 1'b0;
            end
            OP_CLEAR: begin
              state_d  = ST_IDLE;
              icount_d = {CNT_W{1'b0}};
              bp_en_d  = 1'b0;
              bp_hit_d = 1'b0;
            end
            default: state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (ld_acc_s) begin
          ld_rem_d = ld_rem_q - (ADDR_W + 1)'(1);
          if (ld_rem_q == (ADDR_W + 1)'(1)) begin
            state_d  = ST_IDLE;
            icount_d = {CNT_W{1'b0}};
          end else begin
            ld_addr_d = ld_addr_q + ADDR_W'(1);
          end
        end else begin
          ld_rem_d = ld_rem_q;
        end
      end
      ST_RUN: begin
        if (bp_fire_s) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else begin
          if (bud_en_q) begin
            budget_d = budget_q - CNT_W'(1);
          end else begin
            budget_d = budget_q;
          end
          if ((bud_en_q && (budget_q == CNT_W'(1))) || (cmd_acc_s && (cmd_op == OP_HALT))) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Single state register for the FSM and all of its bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ld_addr_q <= {ADDR_W{1'b0}};
      ld_rem_q  <= {(ADDR_W + 1){1'b0}};
      budget_q  <= {CNT_W{1'b0}};
      bud_en_q  <= 1'b0;
      first_q   <= 1'b0;
      bp_en_q   <= 1'b0;
      bp_addr_q <= {ADDR_W{1'b0}};
      bp_hit_q  <= 1'b0;
      icount_q  <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      ld_rem_q  <= ld_rem_d;
      budget_q  <= budget_d;
      bud_en_q  <= bud_en_d;
      first_q   <= first_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      bp_hit_q  <= bp_hit_d;
      icount_q  <= icount_d;
    end
  end

  assign cpu_en    = cpu_en_s;
  assign cpu_rst_n = core_live_in(state_q);
  assign cmd_ready = cmd_ready_in(state_q);
  assign ld_ready  = (state_q == ST_LOAD);
  assign state     = state_q;
  assign bp_hit    = bp_hit_q;
  assign icount    = icount_q;

endmodule

// File: tb/tb_dl166_run_ctrl.sv
// Directed bench for dl166_run_ctrl: reset, load, bounded run, breakpoint and
// step, breakpoint-vs-halt priority, icount saturation, reset mid-load.
module tb_dl166_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_data;
  logic [3:0]  cpu_pc;
  logic [7:0]  cpu_instr;
  logic        cpu_rst_n;
  logic        cpu_en;
  logic [2:0]  state;
  logic        bp_hit;
  logic [15:0] icount;

  int vectors = 0;
  int miscompares = 0;
  int en_cycles;
  logic rst_n_ok;
  logic [7:0] exp_b;

  dl166_run_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .cpu_pc    (cpu_pc),
    .cpu_instr (cpu_instr),
    .cpu_rst_n (cpu_rst_n),
    .cpu_en    (cpu_en),
    .state     (state),
    .bp_hit    (bp_hit),
    .icount    (icount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [15:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = 16'd0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 16'd0;
    ld_valid = 1'b0; ld_data = 8'd0; cpu_pc = 4'd0;

    // 1: reset state
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_state", state, 32'd0);
    chk("rst_cpu_rst_n", cpu_rst_n, 32'd0);
    chk("rst_cpu_en", cpu_en, 32'd0);
    chk("rst_cmd_ready", cmd_ready, 32'd1);
    chk("rst_bp_hit", bp_hit, 32'd0);
    chk("rst_icount", icount, 32'd0);
    for (int i = 0; i < 16; i++) begin
      cpu_pc = 4'(i);
      #1;
      chk("rst_store", cpu_instr, 32'h90);
    end

    // 2: load three bytes
    send_cmd(3'd1, 16'd3);
    chk("load_state", state, 32'd1);
    chk("load_ld_ready", ld_ready, 32'd1);
    chk("load_cmd_ready", cmd_ready, 32'd0);
    ld_valid = 1'b1;
    ld_data = 8'hA1; step();
    ld_data = 8'h60; step();
    ld_data = 8'h90; step();
    ld_valid = 1'b0;
    chk("load_done_ld_ready", ld_ready, 32'd0);
    chk("load_done_state", state, 32'd0);
    cpu_pc = 4'd0; #1; chk("load_w0", cpu_instr, 32'hA1);
    cpu_pc = 4'd1; #1; chk("load_w1", cpu_instr, 32'h60);
    cpu_pc = 4'd2; #1; chk("load_w2", cpu_instr, 32'h90);

    // 3: bounded run of 5
    cpu_pc = 4'd0;
    send_cmd(3'd2, 16'd5);
    chk("run_state", state, 32'd2);
    en_cycles = 0;
    rst_n_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (cpu_en === 1'b1) en_cycles++;
      if (cpu_rst_n !== 1'b1) rst_n_ok = 1'b0;
      step();
    end
    chk("run_en_cycles", en_cycles, 32'd5);
    chk("run_rst_n_held", rst_n_ok, 32'd1);
    chk("run_icount", icount, 32'd5);
    chk("run_halt_state", state, 32'd4);
    chk("run_bp_hit", bp_hit, 32'd0);

    // 4: breakpoint at 3, then single-step off it
    send_cmd(3'd5, 16'd3);
    chk("brkset_state", state, 32'd4);
    send_cmd(3'd2, 16'd0);
    for (int p = 0; p < 3; p++) begin
      cpu_pc = 4'(p);
      #1;
      chk("bp_pre_en", cpu_en, 32'd1);
      step();
    end
    cpu_pc = 4'd3;
    #1;
    chk("bp_at_en", cpu_en, 32'd0);
    step();
    chk("bp_state", state, 32'd4);
    chk("bp_hit_set", bp_hit, 32'd1);
    chk("bp_icount", icount, 32'd8);
    send_cmd(3'd3, 16'd0);
    chk("step_state", state, 32'd3);
    chk("step_bp_hit_clr", bp_hit, 32'd0);
    chk("step_en_at_bp", cpu_en, 32'd1);
    step();
    chk("step_halt", state, 32'd4);
    chk("step_icount", icount, 32'd9);
    chk("step_en_off", cpu_en, 32'd0);

    // 5: breakpoint fires in the same cycle a HALT command is accepted
    send_cmd(3'd5, 16'd5);
    cpu_pc = 4'd4;
    send_cmd(3'd2, 16'd0);
    #1;
    chk("bph_first_en", cpu_en, 32'd1);
    step();
    cpu_pc = 4'd5;
    cmd_valid = 1'b1; cmd_op = 3'd4;
    #1;
    chk("bph_en", cpu_en, 32'd0);
    step();
    cmd_valid = 1'b0; cmd_op = 3'd0;
    chk("bph_state", state, 32'd4);
    chk("bph_bp_hit", bp_hit, 32'd1);
    chk("bph_icount", icount, 32'd10);

    // 5b: icount saturation via a 0xFFFF-instruction budget
    send_cmd(3'd7, 16'd0);
    chk("clear_state", state, 32'd0);
    chk("clear_icount", icount, 32'd0);
    send_cmd(3'd2, 16'hFFFF);
    for (int c = 0; c < 70000 && state != 3'd4; c++) step();
    chk("sat_state", state, 32'd4);
    chk("sat_icount", icount, 32'hFFFF);
    send_cmd(3'd3, 16'd0);
    step();
    chk("sat_hold", icount, 32'hFFFF);

    // 6: async reset partway through a 4-byte load
    send_cmd(3'd7, 16'd0);
    send_cmd(3'd1, 16'd4);
    ld_valid = 1'b1;
    ld_data = 8'h11; step();
    ld_data = 8'h22; step();
    ld_valid = 1'b0;
    cpu_pc = 4'd1; #1;
    chk("mid_load_w1", cpu_instr, 32'h22);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", state, 32'd0);
    chk("arst_ld_ready", ld_ready, 32'd0);
    for (int i = 0; i < 16; i++) begin
      cpu_pc = 4'(i);
      exp_b = 8'h90;
      #1;
      chk("arst_store", cpu_instr, 32'(exp_b));
    end
    reset = 1'b0;
    step();
    chk("arst_cmd_ready", cmd_ready, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
